// File: rtl/audio_mux_pkg.sv
// Shared register map, control/status bit positions and block-fill FSM states
// for the multi-channel CPU audio mux.
package audio_mux_pkg;

    localparam int CH_BASE   = 'h00;
    localparam int CTRL      = 'h10;
    localparam int BUFSIZE   = 'h11;
    localparam int STATUS    = 'h12;
    localparam int FRAME_CNT = 'h13;

    localparam int CTRL_JACK_BIT      = 0;
    localparam int CTRL_IRQ_EN_BIT    = 1;
    localparam int STATUS_DONE_BIT    = 0;
    localparam int STATUS_OVERRUN_BIT = 1;
    localparam int STATUS_CNT_LSB     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/syncro_2.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
module syncro_2 (
    input  logic clk,
    input  logic reset_reg_N,
    input  logic d,
    output logic q
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/audio_mux_mc.sv
// Multi-channel audio frame snapshot exposed on the CPU register bus, with
// I2S / block-fill voice-engine trigger generation, overrun flag and block-done irq.
module audio_mux_mc
    import audio_mux_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int AUD_BIT_DEPTH = 24,
    parameter int FIFO_WIDTH    = 6,
    parameter int ADDR_WIDTH    = 5
) (
    input  logic                            clk,
    input  logic                            reset_reg_N,
    input  logic [ADDR_WIDTH-1:0]           address,
    input  logic                            read,
    input  logic                            write,
    input  logic [31:0]                     datain,
    output logic [31:0]                     dataout,
    input  logic [NUM_CH*AUD_BIT_DEPTH-1:0] sound_in,
    input  logic                            sample_valid,
    input  logic                            xxxx_top,
    input  logic                            lrck,
    input  logic                            run,
    output logic [NUM_CH-1:0]               ch_read,
    output logic                            trig,
    output logic                            i2s_enable,
    output logic                            irq
);
    localparam int CW       = FIFO_WIDTH + 1;
    localparam int CNT_SHOW = (CW > 8) ? 8 : CW;
    localparam logic [ADDR_WIDTH-1:0] A_CTRL      = ADDR_WIDTH'(CTRL);
    localparam logic [ADDR_WIDTH-1:0] A_BUFSIZE   = ADDR_WIDTH'(BUFSIZE);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS    = ADDR_WIDTH'(STATUS);
    localparam logic [ADDR_WIDTH-1:0] A_FRAME_CNT = ADDR_WIDTH'(FRAME_CNT);
    localparam logic [NUM_CH-1:0]     ALL_READ    = '1;

    logic [AUD_BIT_DEPTH-1:0] snap_q [NUM_CH];
    logic [AUD_BIT_DEPTH-1:0] snap_d [NUM_CH];
    logic [31:0]       dataout_q, dataout_d, frame_cnt_q, frame_cnt_d;
    logic              jack_act_q, jack_act_d, jack_prev_q, jack_prev_d;
    logic              irq_en_q, irq_en_d, irq_q, irq_d;
    logic [CW-1:0]     bufsize_q, bufsize_d, active_size_q, active_size_d;
    logic [CW-1:0]     counter_q, counter_d;
    logic              run_trig_q, run_trig_d, block_done_q, block_done_d;
    logic              overrun_q, overrun_d;
    logic [NUM_CH-1:0] read_mask_q, read_mask_d;
    fill_state_e       state_q, state_d;

    logic        lrck_synced;
    logic        jack_rise, jack_fall;
    logic [31:0] status_word, ctrl_word;
    logic [CW:0] issued;
    logic        unused_datain;

    syncro_2 u_lrck_sync (
        .clk         (clk),
        .reset_reg_N (reset_reg_N),
        .d           (lrck),
        .q           (lrck_synced)
    );

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_read[gi] = read && (address == ADDR_WIDTH'(CH_BASE + gi));
            assign snap_d[gi]  = sample_valid ? sound_in[gi*AUD_BIT_DEPTH +: AUD_BIT_DEPTH]
                                              : snap_q[gi];
        end
    endgenerate

    assign jack_rise     = jack_act_q && !jack_prev_q;
    assign jack_fall     = !jack_act_q && jack_prev_q;
    assign unused_datain = ^datain[31:CW];

    always_comb begin
        status_word = '0;
        status_word[STATUS_DONE_BIT]    = block_done_q;
        status_word[STATUS_OVERRUN_BIT] = overrun_q;
        status_word[STATUS_CNT_LSB +: CNT_SHOW] = counter_q[CNT_SHOW-1:0];
        ctrl_word = '0;
        ctrl_word[CTRL_JACK_BIT]   = jack_act_q;
        ctrl_word[CTRL_IRQ_EN_BIT] = irq_en_q;
    end

    always_comb begin
        dataout_d     = dataout_q;
        frame_cnt_d   = frame_cnt_q;
        jack_act_d    = jack_act_q;
        jack_prev_d   = jack_act_q;
        irq_en_d      = irq_en_q;
        bufsize_d     = bufsize_q;
        active_size_d = active_size_q;
        counter_d     = counter_q;
        run_trig_d    = 1'b0;
        block_done_d  = block_done_q;
        overrun_d     = overrun_q;
        read_mask_d   = read_mask_q;
        state_d       = state_q;
        irq_d         = block_done_q && irq_en_q;
        issued        = {1'b0, counter_q} + (CW+1)'(run_trig_q);

        if (read) begin
            unique case (address)
                A_CTRL:      dataout_d = ctrl_word;
                A_BUFSIZE:   dataout_d = 32'(bufsize_q);
                A_STATUS:    dataout_d = status_word;
                A_FRAME_CNT: dataout_d = frame_cnt_q;
                default:     dataout_d = '0;
            endcase
            // Samples are left-justified so software sees a signed 32-bit value.
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_read[i]) dataout_d = 32'(snap_q[i]) << (32 - AUD_BIT_DEPTH);
            end
        end

        if (write) begin
            unique case (address)
                A_CTRL: begin
                    jack_act_d = datain[CTRL_JACK_BIT];
                    irq_en_d   = datain[CTRL_IRQ_EN_BIT];
                end
                A_BUFSIZE: bufsize_d = datain[CW-1:0];
                A_STATUS: begin
                    if (datain[STATUS_DONE_BIT])    block_done_d = 1'b0;
                    if (datain[STATUS_OVERRUN_BIT]) overrun_d    = 1'b0;
                end
                default: ;
            endcase
        end

        // A new frame invalidates the read-tracking of the previous one.
        if (sample_valid) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
            read_mask_d = '0;
            if (read_mask_q != ALL_READ) overrun_d = 1'b1;
        end else begin
            read_mask_d = read_mask_q | ch_read;
        end

        if (jack_fall) begin
            state_d   = IDLE;
            counter_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    counter_d = '0;
                    if (jack_rise && bufsize_q != '0) begin
                        state_d       = FILL;
                        active_size_d = bufsize_q;
                    end
                end
                FILL: begin
                    counter_d = counter_q + CW'(run_trig_q);
                    if (counter_q == active_size_q) begin
                        state_d      = DONE;
                        block_done_d = 1'b1;
                    end else begin
                        // An in-flight pulse already counts toward the block.
                        run_trig_d = xxxx_top && !run && (issued < {1'b0, active_size_q});
                    end
                end
                DONE: begin
                    if (jack_rise) begin
                        counter_d = '0;
                        if (bufsize_q != '0) begin
                            state_d       = FILL;
                            active_size_d = bufsize_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            for (int i = 0; i < NUM_CH; i++) snap_q[i] <= '0;
            dataout_q     <= '0;
            frame_cnt_q   <= '0;
            jack_act_q    <= 1'b0;
            jack_prev_q   <= 1'b0;
            irq_en_q      <= 1'b0;
            irq_q         <= 1'b0;
            bufsize_q     <= '0;
            active_size_q <= '0;
            counter_q     <= '0;
            run_trig_q    <= 1'b0;
            block_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
            read_mask_q   <= '1;
            state_q       <= IDLE;
        end else begin
            for (int i = 0; i < NUM_CH; i++) snap_q[i] <= snap_d[i];
            dataout_q     <= dataout_d;
            frame_cnt_q   <= frame_cnt_d;
            jack_act_q    <= jack_act_d;
            jack_prev_q   <= jack_prev_d;
            irq_en_q      <= irq_en_d;
            irq_q         <= irq_d;
            bufsize_q     <= bufsize_d;
            active_size_q <= active_size_d;
            counter_q     <= counter_d;
            run_trig_q    <= run_trig_d;
            block_done_q  <= block_done_d;
            overrun_q     <= overrun_d;
            read_mask_q   <= read_mask_d;
            state_q       <= state_d;
        end
    end

    assign dataout    = dataout_q;
    assign irq        = irq_q;
    assign i2s_enable = (active_size_q == '0);
    assign trig       = i2s_enable ? lrck_synced : run_trig_q;

endmodule

// File: tb/tb_audio_mux_mc.sv
// Self-checking bench for audio_mux_mc: per-cycle reference model plus directed
// register-bus scenarios with hand-computed expectations.
module tb_audio_mux_mc;
    localparam int NUM_CH = 4;
    localparam int D      = 24;
    localparam int FW     = 6;
    localparam int AW     = 5;

    logic              clk;
    logic              reset_reg_N;
    logic [AW-1:0]     address;
    logic              read, write;
    logic [31:0]       datain, dataout;
    logic [NUM_CH*D-1:0] sound_in;
    logic              sample_valid, xxxx_top, lrck, run;
    logic [NUM_CH-1:0] ch_read;
    logic              trig, i2s_enable, irq;

    audio_mux_mc #(.NUM_CH(NUM_CH), .AUD_BIT_DEPTH(D), .FIFO_WIDTH(FW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_reg_N(reset_reg_N), .address(address), .read(read), .write(write),
        .datain(datain), .dataout(dataout), .sound_in(sound_in), .sample_valid(sample_valid),
        .xxxx_top(xxxx_top), .lrck(lrck), .run(run), .ch_read(ch_read), .trig(trig),
        .i2s_enable(i2s_enable), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    bit top_en = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: register file, frame bookkeeping and block progress.
    logic [D-1:0]      m_snap [NUM_CH];
    logic [31:0]       m_frames, m_dout;
    logic [NUM_CH-1:0] m_mask;
    bit m_over, m_done, m_jack, m_jack_old, m_irq_en, m_irq, m_pulse, m_lr1, m_lrs;
    int m_bufsize, m_active, m_count, m_phase;  // phase: 0 idle, 1 filling, 2 finished

    always @(posedge clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            for (int i = 0; i < NUM_CH; i++) m_snap[i] = '0;
            m_frames = 0; m_dout = 0; m_mask = '1; m_over = 0; m_done = 0;
            m_jack = 0; m_jack_old = 0; m_irq_en = 0; m_irq = 0; m_pulse = 0;
            m_lr1 = 0; m_lrs = 0; m_bufsize = 0; m_active = 0; m_count = 0; m_phase = 0;
        end else begin
            logic [31:0] n_dout;
            logic [NUM_CH-1:0] exp_chr;
            bit n_jack, n_irq_en, n_over, n_done, n_pulse, rise, fall;
            int n_bufsize, n_count, n_phase, n_active;

            exp_chr = '0;
            if (read && address < NUM_CH) exp_chr[address] = 1'b1;
            check32("ch_read", 32'(ch_read), 32'(exp_chr));

            n_dout = m_dout;
            if (read) begin
                if (address < NUM_CH)   n_dout = 32'(m_snap[address]) << (32 - D);
                else if (address == 16) n_dout = {30'd0, m_irq_en, m_jack};
                else if (address == 17) n_dout = 32'(m_bufsize);
                else if (address == 18) n_dout = {16'd0, 8'(m_count), 6'd0, m_over, m_done};
                else if (address == 19) n_dout = m_frames;
                else                    n_dout = 0;
            end

            n_jack = m_jack; n_irq_en = m_irq_en; n_bufsize = m_bufsize;
            n_over = m_over; n_done = m_done;
            if (write && address == 16) begin n_jack = datain[0]; n_irq_en = datain[1]; end
            if (write && address == 17) n_bufsize = int'(datain[FW:0]);
            if (write && address == 18) begin
                if (datain[0]) n_done = 0;
                if (datain[1]) n_over = 0;
            end

            if (sample_valid) begin
                if (m_mask != '1) n_over = 1;
                for (int i = 0; i < NUM_CH; i++) m_snap[i] = sound_in[i*D +: D];
                m_frames = m_frames + 1;
                m_mask = '0;
            end else begin
                m_mask = m_mask | exp_chr;
            end

            rise = m_jack && !m_jack_old;
            fall = !m_jack && m_jack_old;
            n_pulse = 0; n_count = m_count; n_phase = m_phase; n_active = m_active;
            if (fall) begin
                n_phase = 0; n_count = 0;
            end else if (m_phase != 1) begin
                if (m_phase == 0) n_count = 0;
                if (rise) begin
                    n_count = 0;
                    if (m_bufsize != 0) begin n_phase = 1; n_active = m_bufsize; end
                    else n_phase = 0;
                end
            end else begin
                n_count = m_count + int'(m_pulse);
                if (m_count == m_active) begin n_phase = 2; n_done = 1; end
                else n_pulse = xxxx_top && !run && (m_count + int'(m_pulse) < m_active);
            end

            m_irq = m_done && m_irq_en;
            m_lrs = m_lr1; m_lr1 = lrck;
            m_jack_old = m_jack;
            m_dout = n_dout; m_jack = n_jack; m_irq_en = n_irq_en; m_bufsize = n_bufsize;
            m_over = n_over; m_done = n_done; m_pulse = n_pulse;
            m_count = n_count; m_phase = n_phase; m_active = n_active;
        end
    end

    // Per-cycle output compare, away from the active edge.
    always @(posedge clk) begin
        #2;
        if (reset_reg_N) begin
            check32("dataout", dataout, m_dout);
            check32("i2s_enable", 32'(i2s_enable), 32'(m_active == 0));
            check32("trig", 32'(trig), 32'((m_active == 0) ? m_lrs : m_pulse));
            check32("irq", 32'(irq), 32'(m_irq));
            if (!i2s_enable && trig) pulses++;
        end
    end

    initial begin
        lrck = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            lrck = ~lrck;
        end
    end

    initial begin
        int tcnt = 0;
        xxxx_top = 1'b0;
        forever begin
            @(negedge clk);
            tcnt++;
            xxxx_top = top_en && (tcnt % 10 == 0);
        end
    end

    task automatic cpu_write(input int addr, input logic [31:0] data);
        @(negedge clk);
        address = AW'(addr); datain = data; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        $display("wr addr=%02h data=%08h", addr, data);
    endtask

    task automatic cpu_read(input int addr, input logic [31:0] exp, input string name);
        @(negedge clk);
        address = AW'(addr); read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        $display("rd addr=%02h data=%08h", addr, dataout);
        check32(name, dataout, exp);
    endtask

    task automatic push_frame(input logic [NUM_CH*D-1:0] frame);
        @(negedge clk);
        sound_in = frame; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        $display("frame %h", frame);
    endtask

    initial begin
        reset_reg_N = 1'b0; address = '0; read = 0; write = 0; datain = '0;
        sound_in = '0; sample_valid = 0; run = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_reg_N = 1'b1;
        check32("rst_dataout", dataout, 32'h0);
        check32("rst_i2s_enable", 32'(i2s_enable), 32'h1);
        check32("rst_irq", 32'(irq), 32'h0);
        repeat (12) @(negedge clk);

        push_frame({24'h000001, 24'h7FFFFF, 24'h800000, 24'h123456});
        cpu_read(0, 32'h12345600, "ch0");
        cpu_read(1, 32'h80000000, "ch1");
        cpu_read(2, 32'h7FFFFF00, "ch2");
        cpu_read(3, 32'h00000100, "ch3");
        cpu_read(19, 32'h1, "frame_cnt1");

        push_frame({24'hABCDEF, 24'h000002, 24'hFFFFFF, 24'h0F0F0F});
        cpu_read(0, 32'h0F0F0F00, "ch0_f2");
        cpu_read(1, 32'hFFFFFF00, "ch1_f2");
        push_frame({24'h111111, 24'h222222, 24'h333333, 24'h444444});
        cpu_read(18, 32'h00000002, "overrun_set");
        cpu_write(18, 32'h2);
        cpu_read(18, 32'h00000000, "overrun_clr");
        cpu_read(31, 32'h0, "unmapped_1f");
        cpu_read(5, 32'h0, "unmapped_ch5");
        cpu_read(19, 32'h3, "frame_cnt3");

        // Block of 5 with irq enabled.
        top_en = 1'b1;
        pulses = 0;
        cpu_write(17, 32'h5);
        cpu_write(16, 32'h3);
        for (int i = 0; i < 300 && !irq; i++) @(negedge clk);
        check32("irq_block5", 32'(irq), 32'h1);
        check32("pulses_block5", 32'(pulses), 32'd5);
        cpu_read(18, 32'h00000501, "status_block5");

        // Abort a block mid-way, then run the smaller follow-on block.
        cpu_write(18, 32'h1);
        cpu_write(16, 32'h0);
        pulses = 0;
        cpu_write(16, 32'h1);
        for (int i = 0; i < 200 && pulses < 2; i++) @(negedge clk);
        check32("pulses_before_abort", 32'(pulses), 32'd2);
        cpu_write(17, 32'h3);
        cpu_write(16, 32'h0);
        repeat (40) @(negedge clk);
        check32("pulses_after_abort", 32'(pulses), 32'd2);
        cpu_read(18, 32'h00000000, "status_aborted");
        pulses = 0;
        cpu_write(16, 32'h1);
        repeat (60) @(negedge clk);
        check32("pulses_block3", 32'(pulses), 32'd3);
        cpu_read(18, 32'h00000301, "status_block3");
        check32("irq_masked", 32'(irq), 32'h0);

        // Asynchronous reset in the middle of a fill.
        cpu_write(18, 32'h1);
        cpu_write(16, 32'h0);
        cpu_write(16, 32'h3);
        repeat (12) @(negedge clk);
        check32("mid_fill_i2s", 32'(i2s_enable), 32'h0);
        @(posedge clk);
        #4;
        reset_reg_N = 1'b0;
        #1;
        check32("arst_i2s_enable", 32'(i2s_enable), 32'h1);
        check32("arst_trig", 32'(trig), 32'h0);
        check32("arst_irq", 32'(irq), 32'h0);
        check32("arst_dataout", dataout, 32'h0);
        top_en = 1'b0;
        repeat (2) @(negedge clk);
        reset_reg_N = 1'b1;
        cpu_read(16, 32'h0, "ctrl_after_rst");
        cpu_read(17, 32'h0, "bufsize_after_rst");
        cpu_read(19, 32'h0, "frame_after_rst");
        cpu_read(0, 32'h0, "ch0_after_rst");
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
